// File: rtl/ysyx_25030085_pkg.sv
// Shared decode constants for the ysyx_25030085 instruction decode unit.
// Latency: n/a (constants, field offsets, helper functions only).
// Backpressure: n/a.
// Ports: none. Optional RV32M decode is selected by YSYX_25030085_IDU_RV32M_EN in the decoder.
package ysyx_25030085_pkg;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // The only SYSTEM word this unit accepts.
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // ALU opcodes
  localparam logic [4:0] ALU_ADD      = 5'd0;
  localparam logic [4:0] ALU_SLL      = 5'd1;
  localparam logic [4:0] ALU_SLT      = 5'd2;
  localparam logic [4:0] ALU_SLTU     = 5'd3;
  localparam logic [4:0] ALU_XOR      = 5'd4;
  localparam logic [4:0] ALU_SRA      = 5'd5;
  localparam logic [4:0] ALU_SRL      = 5'd6;
  localparam logic [4:0] ALU_OR       = 5'd7;
  localparam logic [4:0] ALU_AND      = 5'd8;
  localparam logic [4:0] ALU_PCIMM    = 5'd9;
  localparam logic [4:0] ALU_SUB      = 5'd10;
  localparam logic [4:0] ALU_MUL_BASE = 5'd16;  // mul..remu = 16 + funct3

  // Write-back select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Jump kind
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  // out_ctrl layout: alu_op occupies [ALUOP_W-1:0]; every other field sits
  // at ALUOP_W + offset below, giving
  // {mem_write, mem_read, mem_op, wb_sel, reg_write, is_branch, br_func, jump, alu_src, alu_op}.
  localparam int OFS_ALU_SRC   = 0;
  localparam int OFS_JUMP      = 1;   // 2 bits
  localparam int OFS_BR_FUNC   = 3;   // 3 bits
  localparam int OFS_IS_BRANCH = 6;
  localparam int OFS_REG_WRITE = 7;
  localparam int OFS_WB_SEL    = 8;   // 2 bits
  localparam int OFS_MEM_OP    = 10;  // 3 bits
  localparam int OFS_MEM_READ  = 13;
  localparam int OFS_MEM_WRITE = 14;
  localparam int CTRL_HI_W     = 15;

  localparam int ALUOP_W_DEF = 5;
  localparam int CTRL_W      = ALUOP_W_DEF + CTRL_HI_W;

  function automatic int ctrl_width(input int aluop_w);
    return aluop_w + CTRL_HI_W;
  endfunction

  // funct3 -> ALU op for the non-subtract, non-arithmetic-shift forms.
  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  typedef enum logic [0:0] {ST_RUN, ST_HALT} idu_state_e;

endpackage

// File: rtl/ysyx_25030085_idu_if.sv
// Instruction-in / decoded-entry-out bundle of the decode unit.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports: master = fetch/execute side driving instructions and out_ready;
//        slave  = the decode unit.
interface ysyx_25030085_idu_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = ysyx_25030085_pkg::CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic              out_ebreak;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_imm,
           out_rd, out_rs1, out_rs2, out_ebreak, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_imm,
           out_rd, out_rs1, out_rs2, out_ebreak, out_illegal
  );
endinterface

// File: rtl/ysyx_25030085_idu_dec.sv
// Combinational RV32I (optionally +M) instruction decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent registers the result on accept.
// Ports: inst in; ctrl/imm/rd/rs1/rs2/ebreak/illegal out.
// Macro YSYX_25030085_IDU_RV32M_EN enables decode of OP funct7=0x01 (mul..remu).
module ysyx_25030085_idu_dec
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  localparam int CW     = ALUOP_W + CTRL_HI_W
) (
  input  logic [31:0]     inst,
  output logic [CW-1:0]   ctrl,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            ebreak,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  // Formed at 32 bits as signed so the XLEN cast sign-extends for RV64.
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]    imm_sh;

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);

  logic       mem_write, mem_read, reg_write, is_branch, alu_src;
  logic [2:0] mem_op, br_func;
  logic [1:0] wb_sel, jump;
  logic [4:0] alu_code;

  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_op    = 3'd0;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    is_branch = 1'b0;
    br_func   = 3'd0;
    jump      = JMP_NONE;
    alu_src   = 1'b0;
    alu_code  = ALU_ADD;
    imm       = '0;
    ebreak    = 1'b0;
    illegal   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
        alu_src   = 1'b1;
        imm       = XLEN'(imm_u);
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_code  = ALU_PCIMM;
        imm       = XLEN'(imm_u);
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        jump      = JMP_JAL;
        alu_src   = 1'b1;
        alu_code  = ALU_PCIMM;
        imm       = XLEN'(imm_j);
      end
      OPC_JALR: begin
        illegal   = (funct3 != 3'd0);
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        jump      = JMP_JALR;
        alu_src   = 1'b1;
        imm       = XLEN'(imm_i);
      end
      OPC_BRANCH: begin
        illegal   = (funct3[2:1] == 2'b01);  // funct3 2 and 3 are unused
        is_branch = 1'b1;
        br_func   = funct3;
        alu_src   = 1'b1;
        alu_code  = ALU_PCIMM;
        imm       = XLEN'(imm_b);
      end
      OPC_LOAD: begin
        illegal   = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
        mem_read  = 1'b1;
        mem_op    = funct3;
        wb_sel    = WB_MEM;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm       = XLEN'(imm_i);
      end
      OPC_STORE: begin
        illegal   = (funct3 > 3'd2);
        mem_write = 1'b1;
        mem_op    = funct3;
        alu_src   = 1'b1;
        imm       = XLEN'(imm_s);
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm       = XLEN'(imm_i);
        alu_code  = alu_from_funct3(funct3);
        if (funct3 == 3'b001) begin
          imm = imm_sh;
        end else if (funct3 == 3'b101) begin
          imm      = imm_sh;
          alu_code = inst[30] ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_OP: begin
        reg_write = 1'b1;
        if (funct7 == 7'h00) begin
          alu_code = alu_from_funct3(funct3);
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'b000)      alu_code = ALU_SUB;
          else if (funct3 == 3'b101) alu_code = ALU_SRA;
          else                       illegal  = 1'b1;
`ifdef YSYX_25030085_IDU_RV32M_EN
        end else if (funct7 == 7'h01) begin
          alu_code = ALU_MUL_BASE + {2'b00, funct3};
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) ebreak  = 1'b1;
        else                     illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Entries that end execution must not cause any architectural side effect.
    if (illegal || ebreak) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      is_branch = 1'b0;
      jump      = JMP_NONE;
    end
  end

  always_comb begin
    ctrl                              = '0;
    ctrl[ALUOP_W-1:0]                 = ALUOP_W'(alu_code);
    ctrl[ALUOP_W+OFS_ALU_SRC]         = alu_src;
    ctrl[ALUOP_W+OFS_JUMP +: 2]       = jump;
    ctrl[ALUOP_W+OFS_BR_FUNC +: 3]    = br_func;
    ctrl[ALUOP_W+OFS_IS_BRANCH]       = is_branch;
    ctrl[ALUOP_W+OFS_REG_WRITE]       = reg_write;
    ctrl[ALUOP_W+OFS_WB_SEL +: 2]     = wb_sel;
    ctrl[ALUOP_W+OFS_MEM_OP +: 3]     = mem_op;
    ctrl[ALUOP_W+OFS_MEM_READ]        = mem_read;
    ctrl[ALUOP_W+OFS_MEM_WRITE]       = mem_write;
  end

endmodule

// File: rtl/ysyx_25030085_idu.sv
// Instruction decode unit: one-entry output register around the decoder, halts on ebreak/illegal.
// Latency: 1 cycle from accept to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready drops while the held entry is stalled, during flush, and forever once halted.
// Ports: clock, reset (sync, active-high), flush, io (slave side of ysyx_25030085_idu_if),
//        out_dec_cnt (accepted-instruction count, wraps at 2^32).
// Macro YSYX_25030085_IDU_RV32M_EN (in the decoder) enables mul..remu decode.
module ysyx_25030085_idu
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  ysyx_25030085_idu_if.slave io,
  output logic [31:0]       out_dec_cnt
);

  localparam int CW = ctrl_width(ALUOP_W);

  idu_state_e      state_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   ctrl_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            ebreak_q, illegal_q;

  logic [CW-1:0]   dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic            dec_ebreak, dec_illegal;
  logic            in_ready, accept;

  ysyx_25030085_idu_dec #(
    .XLEN    (XLEN),
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .inst    (io.in_inst),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .ebreak  (dec_ebreak),
    .illegal (dec_illegal)
  );

  assign in_ready = (state_q == ST_RUN) && !flush && (!valid_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      ctrl_q      <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ebreak_q    <= 1'b0;
      illegal_q   <= 1'b0;
      out_dec_cnt <= '0;
    end else if (flush) begin
      // Flush drops the held entry only; a halted unit stays halted.
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      pc_q        <= io.in_pc;
      ctrl_q      <= dec_ctrl;
      imm_q       <= dec_imm;
      rd_q        <= dec_rd;
      rs1_q       <= dec_rs1;
      rs2_q       <= dec_rs2;
      ebreak_q    <= dec_ebreak;
      illegal_q   <= dec_illegal;
      out_dec_cnt <= out_dec_cnt + 32'd1;
      if (dec_ebreak || dec_illegal) state_q <= ST_HALT;
    end else if (valid_q && io.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = valid_q;
  assign io.out_pc      = pc_q;
  assign io.out_ctrl    = ctrl_q;
  assign io.out_imm     = imm_q;
  assign io.out_rd      = rd_q;
  assign io.out_rs1     = rs1_q;
  assign io.out_rs2     = rs2_q;
  assign io.out_ebreak  = ebreak_q;
  assign io.out_illegal = illegal_q;

endmodule

// File: tb/tb_ysyx_25030085_idu.sv
// Directed bench for ysyx_25030085_idu (XLEN=32, ALUOP_W=5).
// out_ctrl layout, LSB first: alu_op[4:0], alu_src[5], jump[7:6], br_func[10:8],
// is_branch[11], reg_write[12], wb_sel[14:13], mem_op[17:15], mem_read[18], mem_write[19].
module tb_ysyx_25030085_idu;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] out_dec_cnt;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_cnt   = 0;

  ysyx_25030085_idu_if #(.XLEN(32), .CTRL_W(20)) bus ();

  ysyx_25030085_idu #(.XLEN(32), .ALUOP_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .io          (bus),
    .out_dec_cnt (out_dec_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] f_alu(input logic [19:0] c);   return c[4:0];   endfunction
  function automatic logic       f_src(input logic [19:0] c);   return c[5];     endfunction
  function automatic logic [1:0] f_jump(input logic [19:0] c);  return c[7:6];   endfunction
  function automatic logic [2:0] f_brf(input logic [19:0] c);   return c[10:8];  endfunction
  function automatic logic       f_br(input logic [19:0] c);    return c[11];    endfunction
  function automatic logic       f_rw(input logic [19:0] c);    return c[12];    endfunction
  function automatic logic [1:0] f_wb(input logic [19:0] c);    return c[14:13]; endfunction
  function automatic logic [2:0] f_mop(input logic [19:0] c);   return c[17:15]; endfunction
  function automatic logic       f_mrd(input logic [19:0] c);   return c[18];    endfunction
  function automatic logic       f_mwr(input logic [19:0] c);   return c[19];    endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    reset   = 1'b0;
    exp_cnt = 0;
    #1;
  endtask

  // Presents one instruction, requires it to be accepted on the next edge.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    #1;
    check("issue_in_ready", bus.in_ready, 1);
    step();
    exp_cnt++;
    bus.in_valid = 1'b0;
    check("issue_out_valid", bus.out_valid, 1);
    check("issue_out_pc", bus.out_pc, pc);
    check("issue_cnt", out_dec_cnt, exp_cnt);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b1;
    step();
    step();

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ctrl", bus.out_ctrl, 0);
    check("rst_out_imm", bus.out_imm, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_out_rs1", bus.out_rs1, 0);
    check("rst_out_rs2", bus.out_rs2, 0);
    check("rst_ebreak", bus.out_ebreak, 0);
    check("rst_illegal", bus.out_illegal, 0);
    check("rst_cnt", out_dec_cnt, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // addi x1, x0, 5
    issue(32'h0050_0093, 32'h8000_0000);
    check("addi_ctrl", bus.out_ctrl, 20'h01020);
    check("addi_alu", f_alu(bus.out_ctrl), 0);
    check("addi_src", f_src(bus.out_ctrl), 1);
    check("addi_rw", f_rw(bus.out_ctrl), 1);
    check("addi_imm", bus.out_imm, 5);
    check("addi_rd", bus.out_rd, 1);
    check("addi_rs1", bus.out_rs1, 0);
    check("addi_cnt", out_dec_cnt, 1);

    // Stall 3 cycles with srai held at the input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h4032_D293;
    bus.in_pc     = 32'h8000_0004;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", bus.in_ready, 0);
      step();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_pc", bus.out_pc, 32'h8000_0000);
      check("stall_out_imm", bus.out_imm, 5);
      check("stall_out_ctrl", bus.out_ctrl, 20'h01020);
      check("stall_out_rd", bus.out_rd, 1);
      check("stall_cnt", out_dec_cnt, 1);
    end
    bus.out_ready = 1'b1;

    // srai x5, x5, 3 -- back-to-back stream follows.
    issue(32'h4032_D293, 32'h8000_0004);
    check("srai_alu", f_alu(bus.out_ctrl), 5);
    check("srai_ctrl", bus.out_ctrl, 20'h01025);
    check("srai_imm", bus.out_imm, 3);
    check("srai_rd", bus.out_rd, 5);
    check("srai_rs1", bus.out_rs1, 5);

    // lw x3, 8(x2)
    issue(32'h0081_2183, 32'h8000_0008);
    check("lw_mrd", f_mrd(bus.out_ctrl), 1);
    check("lw_mwr", f_mwr(bus.out_ctrl), 0);
    check("lw_mop", f_mop(bus.out_ctrl), 2);
    check("lw_wb", f_wb(bus.out_ctrl), 1);
    check("lw_rw", f_rw(bus.out_ctrl), 1);
    check("lw_imm", bus.out_imm, 8);
    check("lw_rd", bus.out_rd, 3);
    check("lw_rs1", bus.out_rs1, 2);

    // sw x5, -4(x2)
    issue(32'hFE51_2E23, 32'h8000_000C);
    check("sw_mwr", f_mwr(bus.out_ctrl), 1);
    check("sw_mrd", f_mrd(bus.out_ctrl), 0);
    check("sw_mop", f_mop(bus.out_ctrl), 2);
    check("sw_rw", f_rw(bus.out_ctrl), 0);
    check("sw_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("sw_rs2", bus.out_rs2, 5);

    // bne x1, x2, -4
    issue(32'hFE20_9EE3, 32'h8000_0010);
    check("bne_br", f_br(bus.out_ctrl), 1);
    check("bne_brf", f_brf(bus.out_ctrl), 1);
    check("bne_rw", f_rw(bus.out_ctrl), 0);
    check("bne_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("bne_rs1", bus.out_rs1, 1);
    check("bne_rs2", bus.out_rs2, 2);

    // jal x1, 8
    issue(32'h0080_00EF, 32'h8000_0014);
    check("jal_jump", f_jump(bus.out_ctrl), 2'b01);
    check("jal_wb", f_wb(bus.out_ctrl), 2);
    check("jal_rw", f_rw(bus.out_ctrl), 1);
    check("jal_imm", bus.out_imm, 8);
    check("jal_rd", bus.out_rd, 1);

    // jalr x0, 0(x1)
    issue(32'h0000_8067, 32'h8000_0018);
    check("jalr_jump", f_jump(bus.out_ctrl), 2'b10);
    check("jalr_wb", f_wb(bus.out_ctrl), 2);
    check("jalr_imm", bus.out_imm, 0);
    check("jalr_rs1", bus.out_rs1, 1);

    // lui x1, 0x12345
    issue(32'h1234_50B7, 32'h8000_001C);
    check("lui_wb", f_wb(bus.out_ctrl), 3);
    check("lui_rw", f_rw(bus.out_ctrl), 1);
    check("lui_imm", bus.out_imm, 32'h1234_5000);
    check("lui_rd", bus.out_rd, 1);

    // sub x3, x1, x2
    issue(32'h4020_81B3, 32'h8000_0020);
    check("sub_alu", f_alu(bus.out_ctrl), 10);
    check("sub_src", f_src(bus.out_ctrl), 0);
    check("sub_rw", f_rw(bus.out_ctrl), 1);
    check("sub_rd", bus.out_rd, 3);

    // Drain.
    step();
    check("drain_out_valid", bus.out_valid, 0);

    // Flush blocks intake even with in_valid high.
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h0050_0093;
    bus.in_pc    = 32'h8000_0024;
    flush        = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_cnt", out_dec_cnt, exp_cnt);

    // Flush overrides a stalled entry.
    issue(32'h0050_0093, 32'h8000_0028);
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    step();
    flush = 1'b0;
    check("flush_stall_valid", bus.out_valid, 0);
    check("flush_stall_cnt", out_dec_cnt, exp_cnt);
    bus.out_ready = 1'b1;

    // Reset mid-stall with another instruction offered.
    issue(32'h0050_0093, 32'h8000_002C);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h1234_50B7;
    reset         = 1'b1;
    step();
    reset         = 1'b0;
    exp_cnt       = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_stall_valid", bus.out_valid, 0);
    check("rst_stall_ctrl", bus.out_ctrl, 0);
    check("rst_stall_pc", bus.out_pc, 0);
    check("rst_stall_cnt", out_dec_cnt, 0);
    check("rst_stall_in_ready", bus.in_ready, 1);

    // ebreak halts; entry still presented.
    issue(32'h0010_0073, 32'h8000_0030);
    check("ebreak_flag", bus.out_ebreak, 1);
    check("ebreak_illegal", bus.out_illegal, 0);
    check("ebreak_rw", f_rw(bus.out_ctrl), 0);
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h0050_0093;
    #1;
    check("halt_in_ready0", bus.in_ready, 0);
    step();
    check("halt_out_valid", bus.out_valid, 0);
    check("halt_in_ready1", bus.in_ready, 0);
    step();
    check("halt_cnt", out_dec_cnt, exp_cnt);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("halt_flush_in_ready", bus.in_ready, 0);
    do_reset();
    check("halt_rst_in_ready", bus.in_ready, 1);
    check("halt_rst_cnt", out_dec_cnt, 0);

    // mul x3, x1, x2
    issue(32'h0220_81B3, 32'h8000_0040);
`ifdef YSYX_25030085_IDU_RV32M_EN
    check("mul_alu", f_alu(bus.out_ctrl), 16);
    check("mul_rw", f_rw(bus.out_ctrl), 1);
    check("mul_wb", f_wb(bus.out_ctrl), 0);
    check("mul_illegal", bus.out_illegal, 0);
    check("mul_in_ready", bus.in_ready, 1);
`else
    check("mul_illegal", bus.out_illegal, 1);
    check("mul_rw", f_rw(bus.out_ctrl), 0);
    check("mul_ebreak", bus.out_ebreak, 0);
    check("mul_halt_in_ready", bus.in_ready, 0);
`endif
    do_reset();

    // ecall is illegal here.
    issue(32'h0000_0073, 32'h8000_0050);
    check("ecall_illegal", bus.out_illegal, 1);
    check("ecall_ebreak", bus.out_ebreak, 0);
    check("ecall_halt_in_ready", bus.in_ready, 0);
    do_reset();

    // Load with funct3=3.
    issue(32'h0001_3183, 32'h8000_0060);
    check("ld_illegal", bus.out_illegal, 1);
    check("ld_mrd", f_mrd(bus.out_ctrl), 0);
    check("ld_rw", f_rw(bus.out_ctrl), 0);
    do_reset();

    // Unknown opcode.
    issue(32'h0000_007F, 32'h8000_0070);
    check("unk_illegal", bus.out_illegal, 1);
    check("unk_in_ready", bus.in_ready, 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_idu.md
YSYX_25030085_IDU -- requirements
Module: ysyx_25030085_idu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter ALUOP_W, default 5, meaning ALU opcode width.
REQ-003 SHALL have port clock  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  out  1  block accepts an instruction this cycle.
REQ-007 SHALL have port in_inst  in  32  instruction word.
REQ-008 SHALL have port in_pc  in  XLEN  instruction address.
REQ-009 SHALL have port flush  in  1  discard output entry and block intake this cycle.
REQ-010 SHALL have port out_valid  out  1  decoded entry valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the entry.
REQ-012 SHALL have port out_pc  out  XLEN  pc of the entry.
REQ-013 SHALL have port out_ctrl  out  CTRL_W  packed fields: mem_write, mem_read, mem_op[2:0], wb_sel[1:0], reg_write, is_branch, br_func[2:0], jump[1:0], alu_src, alu_op[ALUOP_W-1:0].
REQ-014 SHALL have port out_imm  out  XLEN  sign- or zero-extended immediate.
REQ-015 SHALL have port out_rd/out_rs1/out_rs2  out  5 each  register indices.
REQ-016 SHALL have port out_ebreak  out  1  entry is ebreak.
REQ-017 SHALL have port out_illegal  out  1  entry is an illegal encoding.
REQ-018 SHALL have port out_dec_cnt  out  32  accepted-instruction count, wraps at 2^32.

Function
REQ-019 SHALL compute in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
REQ-020 SHALL, on accept (in_valid && in_ready), register the decoded entry at the next edge with out_valid=1: one-cycle latency, full throughput.
REQ-021 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid at the next edge when flush=1; flush overrides out_ready and takes priority over accept.
REQ-023 SHALL use alu_op codes add 0, sll 1, slt 2, sltu 3, xor 4, sra 5, srl 6, or 7, and 8, pc+imm 9, sub 10.
REQ-024 SHALL use wb_sel codes 0 ALU, 1 memory, 2 pc+4, 3 imm (lui), jump codes 01 jal and 10 jalr, and mem_op = funct3 for loads and stores.
REQ-025 SHALL output is_branch=1 and br_func=funct3 for branches; no operand comparison is done here.
REQ-026 SHALL sign-extend I/S/B/U/J immediates to XLEN; shift-immediates use zero-extended shamt of 5 bits (XLEN=32) or 6 bits (XLEN=64).
REQ-027 SHALL flag illegal: unknown opcode, R-type funct7 outside {0x00,0x20} (plus 0x01 under REQ-035), funct7=0x20 with funct3 not 000/101, load funct3 3/6/7, store funct3>2, branch funct3 2/3, jalr funct3≠0, any SYSTEM word other than 0x00100073.
REQ-028 SHALL force out_ctrl write enables (reg_write, mem_write, mem_read, is_branch, jump) to 0 for illegal and ebreak entries.
REQ-029 SHALL run an FSM RUN→HALT on accepting an ebreak or illegal instruction; that entry is still presented; HALT exits only via reset.
REQ-030 SHALL keep state HALT under flush; flush in HALT clears out_valid only.
REQ-031 SHALL increment out_dec_cnt by 1 per accept, wrapping 0xFFFFFFFF→0.

Reset
REQ-032 SHALL, on reset, set state=RUN, out_valid=0, out_ctrl=0, out_imm=0, out_pc=0, out_rd/rs1/rs2=0, out_ebreak=0, out_illegal=0, out_dec_cnt=0.
REQ-033 SHALL give reset priority over flush, accept and HALT.
REQ-034 SHALL discard any in-flight entry on reset mid-stall.

Configuration
REQ-035 SHALL, with YSYX_25030085_IDU_RV32M_EN defined, decode opcode 0x33 funct7=0x01 to alu_op 16+funct3 (mul..remu), reg_write=1, wb_sel=0.
REQ-036 SHALL, without YSYX_25030085_IDU_RV32M_EN, flag those encodings illegal.

Structure
REQ-037 SHALL keep opcode constants, alu_op/wb_sel/jump codes, CTRL_W and out_ctrl field offsets in shared package ysyx_25030085_pkg.
REQ-038 SHALL place combinational decode in sub-module ysyx_25030085_idu_dec; handshake, FSM, counter and output register live in the top.

Verification
REQ-039 SHALL check 0x00500093 at pc 0x80000000 → next cycle out_valid=1, alu_op=0, alu_src=1, imm=5, rd=1, reg_write=1, out_dec_cnt=1.
REQ-040 SHALL check out_valid=1, out_ready=0 for 3 cycles → in_ready=0, outputs unchanged, next instruction held; out_ready=1 → it is accepted.
REQ-041 SHALL check 0x4032D293 → alu_op=5, imm=3, rd=5, rs1=5.
REQ-042 SHALL check 0x00100073 → out_ebreak=1, reg_write=0, state HALT, in_ready=0 until reset; after reset in_ready=1.
REQ-043 SHALL check 0x022081B3 → alu_op=16 with macro; out_illegal=1 and HALT without it.
REQ-044 SHALL check flush=1 with in_valid=1 → in_ready=0, out_valid=0 next cycle, out_dec_cnt unchanged.
